// File: rtl/writeback_stage_pkg.sv
// Shared types for the writeback stage: load size encodings, FSM states and width defaults.
// Also used by the load extractor and the later store-merge unit.
package writeback_stage_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  typedef enum logic [1:0] {
    LS_WORD = 2'b00,
    LS_HALF = 2'b01,
    LS_BYTE = 2'b10,
    LS_RSVD = 2'b11
  } load_size_e;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM-to-WB handshake bundle: the instruction the MEM stage presents plus the stall back to it.
interface writeback_stage_if
  import writeback_stage_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
);

  logic              m_valid;
  logic              m_regwrite;
  logic              m_memtoreg;
  logic [ADDR_W-1:0] m_wa;
  logic [DATA_W-1:0] m_alu_result;
  logic [1:0]        m_load_size;
  logic              m_load_signed;
  logic [DATA_W-1:0] m_load_data;
  logic              m_load_ready;
  logic              wb_stall;

  modport master (
    output m_valid, m_regwrite, m_memtoreg, m_wa, m_alu_result,
           m_load_size, m_load_signed, m_load_data, m_load_ready,
    input  wb_stall
  );

  modport slave (
    input  m_valid, m_regwrite, m_memtoreg, m_wa, m_alu_result,
           m_load_size, m_load_signed, m_load_data, m_load_ready,
    output wb_stall
  );

endinterface

// File: rtl/writeback_stage_load_extract.sv
// Big-endian sub-word select and sign/zero extension of a raw data-memory word.
module writeback_stage_load_extract
  import writeback_stage_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W
) (
  input  logic [DATA_W-1:0] data,
  input  load_size_e        size,
  input  logic              is_signed,
  input  logic [1:0]        addr,
  output logic [DATA_W-1:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane 0 is the most significant byte.
  always_comb begin
    byte_sel = data[31:24];
    case (addr)
      2'd0: byte_sel = data[31:24];
      2'd1: byte_sel = data[23:16];
      2'd2: byte_sel = data[15:8];
      2'd3: byte_sel = data[7:0];
      default: byte_sel = data[31:24];
    endcase
  end

  assign half_sel = addr[1] ? data[15:0] : data[31:16];

  always_comb begin
    value = data;
    case (size)
      LS_BYTE: value = {{(DATA_W-8){is_signed & byte_sel[7]}}, byte_sel};
      LS_HALF: value = {{(DATA_W-16){is_signed & half_sel[15]}}, half_sel};
      default: value = data;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with slow-load wait FSM, register file write port and ID bypass.
//
// state        | meaning
// WB_IDLE      | accepting from MEM; stalls combinationally if a load arrives unready
// WB_WAIT_LOAD | load control latched, upstream frozen until m_load_ready
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  writeback_stage_if.slave    mem,
  output logic [ADDR_W-1:0]   wa,
  output logic [DATA_W-1:0]   wd,
  output logic                regwrite,
  input  logic [ADDR_W-1:0]   id_ra1,
  input  logic [ADDR_W-1:0]   id_ra2,
  input  logic [DATA_W-1:0]   rf_rd1,
  input  logic [DATA_W-1:0]   rf_rd2,
  output logic [DATA_W-1:0]   id_rd1,
  output logic [DATA_W-1:0]   id_rd2
);

  wb_state_e         state;
  logic              valid_q;
  logic              wb_regwrite_q;
  logic [ADDR_W-1:0] wa_q;
  logic [DATA_W-1:0] wd_q;
  load_size_e        pend_size;
  logic              pend_signed;
  logic [1:0]        pend_addr;

  load_size_e        ext_size;
  logic              ext_signed;
  logic [1:0]        ext_addr;
  logic [DATA_W-1:0] ext_value;
  logic              load_unready;

  assign load_unready = mem.m_valid & mem.m_memtoreg & ~mem.m_load_ready;

  // While waiting, the extractor must use the latched control, not the frozen bus.
  always_comb begin
    ext_size   = load_size_e'(mem.m_load_size);
    ext_signed = mem.m_load_signed;
    ext_addr   = mem.m_alu_result[1:0];
    if (state == WB_WAIT_LOAD) begin
      ext_size   = pend_size;
      ext_signed = pend_signed;
      ext_addr   = pend_addr;
    end
  end

  writeback_stage_load_extract #(.DATA_W(DATA_W)) u_load_extract (
    .data      (mem.m_load_data),
    .size      (ext_size),
    .is_signed (ext_signed),
    .addr      (ext_addr),
    .value     (ext_value)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= WB_IDLE;
      valid_q       <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wa_q          <= '0;
      wd_q          <= '0;
      pend_size     <= LS_WORD;
      pend_signed   <= 1'b0;
      pend_addr     <= 2'b00;
    end else begin
      case (state)
        WB_IDLE: begin
          if (load_unready) begin
            wb_regwrite_q <= mem.m_regwrite;
            wa_q          <= mem.m_wa;
            pend_size     <= load_size_e'(mem.m_load_size);
            pend_signed   <= mem.m_load_signed;
            pend_addr     <= mem.m_alu_result[1:0];
            valid_q       <= 1'b0;
            state         <= WB_WAIT_LOAD;
          end else if (mem.m_valid) begin
            valid_q       <= 1'b1;
            wb_regwrite_q <= mem.m_regwrite;
            wa_q          <= mem.m_wa;
            wd_q          <= mem.m_memtoreg ? ext_value : mem.m_alu_result;
          end else begin
            valid_q <= 1'b0;
          end
        end
        WB_WAIT_LOAD: begin
          if (mem.m_load_ready) begin
            wd_q    <= ext_value;
            valid_q <= 1'b1;
            state   <= WB_IDLE;
          end else begin
            valid_q <= 1'b0;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state   <= WB_IDLE;
        end
      endcase
    end
  end

  assign mem.wb_stall = (state == WB_WAIT_LOAD) | ((state == WB_IDLE) & load_unready);

  // A zero address kills the write, which also keeps $0 out of the bypass.
  assign regwrite = valid_q & wb_regwrite_q & (wa_q != '0);
  assign wa       = wa_q;
  assign wd       = wd_q;

  assign id_rd1 = (regwrite && (wa_q == id_ra1)) ? wd_q : rf_rd1;
  assign id_rd2 = (regwrite && (wa_q == id_ra2)) ? wd_q : rf_rd2;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: ALU and load writes, slow load stall, $0, bypass, async reset.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        regwrite;
  logic [4:0]  id_ra1, id_ra2;
  logic [31:0] rf_rd1, rf_rd2;
  logic [31:0] id_rd1, id_rd2;

  int n_cmp = 0;
  int n_bad = 0;

  writeback_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  writeback_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem      (bus),
    .wa       (wa),
    .wd       (wd),
    .regwrite (regwrite),
    .id_ra1   (id_ra1),
    .id_ra2   (id_ra2),
    .rf_rd1   (rf_rd1),
    .rf_rd2   (rf_rd2),
    .id_rd1   (id_rd1),
    .id_rd2   (id_rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus.m_valid       = 1'b0;
    bus.m_regwrite    = 1'b0;
    bus.m_memtoreg    = 1'b0;
    bus.m_wa          = '0;
    bus.m_alu_result  = '0;
    bus.m_load_size   = LS_WORD;
    bus.m_load_signed = 1'b0;
    bus.m_load_data   = '0;
    bus.m_load_ready  = 1'b0;
  endtask

  // One-cycle ready load presented at a negedge, checked at the following negedge.
  task automatic fast_load(input string tag, input logic [1:0] size, input logic sgn,
                           input logic [1:0] addr, input logic [31:0] data,
                           input logic [31:0] exp);
    bus.m_valid       = 1'b1;
    bus.m_regwrite    = 1'b1;
    bus.m_memtoreg    = 1'b1;
    bus.m_wa          = 5'd4;
    bus.m_alu_result  = {30'h0000_1000, addr};
    bus.m_load_size   = size;
    bus.m_load_signed = sgn;
    bus.m_load_data   = data;
    bus.m_load_ready  = 1'b1;
    #1 chk({tag, "_stall"}, 32'(bus.wb_stall), 32'd0);
    @(negedge clk);
    idle_bus();
    #1;
    chk({tag, "_wd"}, wd, exp);
    chk({tag, "_regwrite"}, 32'(regwrite), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    idle_bus();
    id_ra1 = '0; id_ra2 = '0; rf_rd1 = '0; rf_rd2 = '0;
    #12;
    chk("rst_regwrite", 32'(regwrite), 32'd0);
    chk("rst_wa", 32'(wa), 32'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_stall", 32'(bus.wb_stall), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // ALU write
    @(negedge clk);
    bus.m_valid = 1'b1; bus.m_regwrite = 1'b1; bus.m_memtoreg = 1'b0;
    bus.m_wa = 5'd5; bus.m_alu_result = 32'h1234_5678;
    @(negedge clk);
    idle_bus();
    #1;
    chk("alu_regwrite", 32'(regwrite), 32'd1);
    chk("alu_wa", 32'(wa), 32'd5);
    chk("alu_wd", wd, 32'h1234_5678);
    @(negedge clk);
    #1 chk("alu_bubble_regwrite", 32'(regwrite), 32'd0);

    // Sub-word loads
    @(negedge clk);
    fast_load("lb_s0", LS_BYTE, 1'b1, 2'd0, 32'h80FF_7F01, 32'hFFFF_FF80);
    @(negedge clk);
    fast_load("lbu0", LS_BYTE, 1'b0, 2'd0, 32'h80FF_7F01, 32'h0000_0080);
    @(negedge clk);
    fast_load("lh_s2", LS_HALF, 1'b1, 2'd2, 32'h80FF_7F01, 32'h0000_7F01);
    @(negedge clk);
    fast_load("lb_s1", LS_BYTE, 1'b1, 2'd1, 32'h80FF_7F01, 32'hFFFF_FFFF);
    @(negedge clk);
    fast_load("lbu3", LS_BYTE, 1'b0, 2'd3, 32'h80FF_7F01, 32'h0000_0001);
    @(negedge clk);
    fast_load("lh_s1", LS_HALF, 1'b1, 2'd1, 32'h80FF_7F01, 32'hFFFF_80FF);
    @(negedge clk);
    fast_load("lw", LS_WORD, 1'b1, 2'd0, 32'h80FF_7F01, 32'h80FF_7F01);
    @(negedge clk);
    fast_load("lrsvd", LS_RSVD, 1'b1, 2'd3, 32'h80FF_7F01, 32'h80FF_7F01);

    // Slow word load: issue cycle plus three wait cycles stall
    @(negedge clk);
    bus.m_valid = 1'b1; bus.m_regwrite = 1'b1; bus.m_memtoreg = 1'b1;
    bus.m_wa = 5'd9; bus.m_alu_result = 32'h0000_2000;
    bus.m_load_size = LS_WORD; bus.m_load_signed = 1'b0; bus.m_load_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin
        bus.m_wa = 5'd3; bus.m_load_size = LS_BYTE; bus.m_alu_result = 32'h0000_2003;
      end
      if (c == 3) begin
        bus.m_load_ready = 1'b1; bus.m_load_data = 32'hDEAD_BEEF;
      end
      #1;
      chk($sformatf("slow_stall_c%0d", c), 32'(bus.wb_stall), 32'd1);
      chk($sformatf("slow_regwrite_c%0d", c), 32'(regwrite), 32'd0);
      @(negedge clk);
    end
    idle_bus();
    #1;
    chk("slow_done_stall", 32'(bus.wb_stall), 32'd0);
    chk("slow_done_regwrite", 32'(regwrite), 32'd1);
    chk("slow_done_wa", 32'(wa), 32'd9);
    chk("slow_done_wd", wd, 32'hDEAD_BEEF);

    // $0 write is suppressed and never bypassed
    @(negedge clk);
    bus.m_valid = 1'b1; bus.m_regwrite = 1'b1; bus.m_wa = 5'd0;
    bus.m_alu_result = 32'hFFFF_FFFF;
    @(negedge clk);
    idle_bus();
    id_ra1 = 5'd0; rf_rd1 = 32'h0000_1111;
    #1;
    chk("zero_regwrite", 32'(regwrite), 32'd0);
    chk("zero_id_rd1", id_rd1, 32'h0000_1111);

    // Bypass
    @(negedge clk);
    bus.m_valid = 1'b1; bus.m_regwrite = 1'b1; bus.m_wa = 5'd7;
    bus.m_alu_result = 32'hAAAA_5555;
    @(negedge clk);
    idle_bus();
    id_ra1 = 5'd7; id_ra2 = 5'd8; rf_rd1 = 32'h7; rf_rd2 = 32'h8;
    #1;
    chk("byp_id_rd1", id_rd1, 32'hAAAA_5555);
    chk("byp_id_rd2", id_rd2, 32'h8);
    id_ra2 = 5'd7;
    #1 chk("byp_id_rd2_hit", id_rd2, 32'hAAAA_5555);
    @(negedge clk);
    #1 chk("byp_expired_id_rd1", id_rd1, 32'h7);

    // Non-writing instruction does not bypass
    @(negedge clk);
    bus.m_valid = 1'b1; bus.m_regwrite = 1'b0; bus.m_wa = 5'd7;
    bus.m_alu_result = 32'h0BAD_0BAD;
    @(negedge clk);
    idle_bus();
    #1;
    chk("nowrite_regwrite", 32'(regwrite), 32'd0);
    chk("nowrite_id_rd1", id_rd1, 32'h7);

    // Asynchronous reset while waiting on a load
    @(negedge clk);
    bus.m_valid = 1'b1; bus.m_regwrite = 1'b1; bus.m_memtoreg = 1'b1;
    bus.m_wa = 5'd12; bus.m_load_ready = 1'b0;
    @(negedge clk);
    idle_bus();
    #1;
    chk("rwait_stall_before", 32'(bus.wb_stall), 32'd1);
    chk("rwait_wa_before", 32'(wa), 32'd12);
    #1 rst = 1'b0;
    #1;
    chk("rwait_stall", 32'(bus.wb_stall), 32'd0);
    chk("rwait_regwrite", 32'(regwrite), 32'd0);
    chk("rwait_wa", 32'(wa), 32'd0);
    chk("rwait_wd", wd, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.m_load_ready = 1'b1; bus.m_load_data = 32'h1357_9BDF;
    @(negedge clk);
    idle_bus();
    #1;
    chk("rwait_after_regwrite", 32'(regwrite), 32'd0);
    chk("rwait_after_wa", 32'(wa), 32'd0);
    chk("rwait_after_stall", 32'(bus.wb_stall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Write-side partner of the pipeline register file. Sits between the MEM stage and the register file write port.
- Holds the MEM/WB pipeline register. Waits on slow load data through a small FSM.
- Extracts and extends sub-word load data, then drives the register file write address, data and enable (wa/wd/regwrite).
- Provides same-cycle write-through bypass on the ID-stage read data, so a register written this cycle is seen by the instruction reading it.

Parameters:
- DATA_W, 32, datapath width (only 32 supported for sub-word extraction).
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- m_valid  in  1  MEM stage presents an instruction.
- m_regwrite  in  1  instruction writes a register.
- m_memtoreg  in  1  1 = load result, 0 = ALU result.
- m_wa  in  ADDR_W  destination register.
- m_alu_result  in  DATA_W  ALU result; also the load address.
- m_load_size  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word).
- m_load_signed  in  1  sign-extend sub-word loads.
- m_load_data  in  DATA_W  raw data-memory word.
- m_load_ready  in  1  m_load_data valid this cycle.
- wb_stall  out  1  freeze MEM and earlier stages.
- wa  out  ADDR_W  register file write address.
- wd  out  DATA_W  register file write data.
- regwrite  out  1  register file write enable.
- id_ra1, id_ra2  in  ADDR_W  ID-stage read addresses.
- rf_rd1, rf_rd2  in  DATA_W  register file read data.
- id_rd1, id_rd2  out  DATA_W  bypassed read data to ID.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - WB register valid=0, regwrite=0, wa=0, wd=0.
  - wb_stall=0.
  - Reset mid-wait abandons the pending load; no write occurs.
- Reset release: takes effect on the first rising edge with rst=1.
- FSM states: IDLE, WAIT_LOAD.
- IDLE, accept case: if m_valid and NOT(m_memtoreg and not m_load_ready), then on the rising edge capture:
  - valid=1, regwrite=m_regwrite, wa=m_wa.
  - wd = the extracted load value if m_memtoreg, else m_alu_result.
- IDLE, load not ready: if m_valid & m_memtoreg & ~m_load_ready:
  - Latch regwrite, wa, size, signed and address low bits.
  - Set valid=0 and go to WAIT_LOAD.
- IDLE, no instruction: if m_valid=0, load valid=0.
- WAIT_LOAD:
  - Each cycle m_load_ready=0: stay, valid=0.
  - On the first cycle with m_load_ready=1: capture the extracted value with the latched control, valid=1, go to IDLE.
  - m_valid and the other m_* inputs are ignored in this state (upstream is frozen).
- wb_stall (combinational) = (state==WAIT_LOAD) or (state==IDLE & m_valid & m_memtoreg & ~m_load_ready).
- Latency: result is visible on wa/wd/regwrite one cycle after acceptance. The register file commits it on the following rising edge.
- regwrite = valid & wb_regwrite & (wa != 0). Writes to $0 are suppressed.
- Load extraction (big-endian, addr = m_alu_result[1:0]):
  - Byte lane at addr 0 is bits [31:24]; addr 3 is bits [7:0].
  - Half selects [31:16] when addr[1]=0, else [15:0]; addr[0] is ignored.
  - Sign-extend if m_load_signed, else zero-extend.
- Bypass (combinational):
  - id_rd1 = wd if regwrite and wa==id_ra1, else rf_rd1. id_rd2 likewise.
  - ra==0 never hits, because regwrite is already 0 for wa==0.

Decomposition:
- Shared package holds:
  - Load size encodings LS_WORD, LS_HALF, LS_BYTE.
  - FSM state encoding.
  - DATA_W/ADDR_W defaults.
- One natural sub-module: load_extract (combinational byte/half select plus extension), reused by a later store-merge unit.

Test Plan:
1. ALU op: m_valid=1, regwrite=1, memtoreg=0, wa=5, alu=0x1234_5678 -> next cycle regwrite=1, wa=5, wd=0x1234_5678.
2. Signed byte load: data=0x80FF_7F01, addr=0, size=byte, signed=1, ready=1 -> wd=0xFFFF_FF80. Same with signed=0 -> wd=0x0000_0080. Half, addr=2, signed=1 -> wd=0x0000_7F01.
3. Slow load: memtoreg=1, ready=0 for 3 cycles then 1, data=0xDEAD_BEEF, size=word, wa=9 -> wb_stall high for 4 cycles (the issue cycle plus the 3 wait-state cycles; the ready cycle itself is a WAIT_LOAD cycle and still stalls), regwrite=0 throughout, then one cycle with regwrite=1, wa=9, wd=0xDEAD_BEEF, wb_stall=0.
4. $0 write: wa=0, regwrite=1, alu=0xFFFF_FFFF -> regwrite stays 0. With id_ra1=0, id_rd1 passes rf_rd1.
5. Bypass: WB holds wa=7, wd=0xAAAA_5555; id_ra1=7, id_ra2=8, rf_rd1=0x7, rf_rd2=0x8 -> id_rd1=0xAAAA_5555, id_rd2=0x8.
6. Reset mid-wait: enter WAIT_LOAD, drop rst to 0 asynchronously between edges -> wb_stall, regwrite, wa and wd go to 0 immediately. After release, a ready=1 pulse causes no write.
